// File: rtl/bt_pipeout_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bt_pipeout_pkg                                                             |
// | Shared types, constants and parameter check for the block-throttled pipe.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package bt_pipeout_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        XFER  = 2'd2
    } bt_state_e;

    // Block size must be a power of two, at least 2, and fit in the FIFO.
    function automatic bit params_ok(input int depth_log2, input int block_words);
        bit pow2;
        pow2 = (block_words > 0) && ((block_words & (block_words - 1)) == 0);
        return pow2 && (block_words >= 2) && (depth_log2 >= 1) && (depth_log2 < 31)
               && (block_words <= (1 << depth_log2));
    endfunction

endpackage
`default_nettype wire

// File: rtl/bt_pipeout_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bt_pipeout_ram                                                             |
// | Simple dual-port 2**ADDR_W x DATA_W memory with registered read port.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bt_pipeout_ram
    import bt_pipeout_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/bt_pipeout_source.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bt_pipeout_source                                                          |
// | FIFO-backed producer for a block-throttled pipe-out endpoint.              |
// | Optional macro BT_PIPEOUT_SOURCE_STATS_EN adds word/block counters.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bt_pipeout_source
    import bt_pipeout_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int BLOCK_WORDS = 256
) (
    input  logic                  okClk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    input  logic                  ep_read,
    input  logic                  ep_blockstrobe,
    output logic [DATA_W-1:0]     ep_datain,
    output logic                  ep_ready,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  proto_err
`ifdef BT_PIPEOUT_SOURCE_STATS_EN
    ,
    output logic [31:0]           words_sent,
    output logic [15:0]           blocks_sent
`endif
);

    localparam int                c_cnt_w = $clog2(BLOCK_WORDS);
    localparam logic [DEPTH_LOG2:0] c_depth = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0] c_block = (DEPTH_LOG2 + 1)'(BLOCK_WORDS);
    localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(BLOCK_WORDS - 1);

    generate
        if (!params_ok(DEPTH_LOG2, BLOCK_WORDS)) begin : g_param_err
            $error("bt_pipeout_source: illegal DEPTH_LOG2/BLOCK_WORDS combination");
        end
    endgenerate

    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic [DEPTH_LOG2:0]   w_level_next;
    bt_state_e             r_state;
    bt_state_e             w_state_next;
    logic [c_cnt_w-1:0]    r_blk_cnt;
    logic [c_cnt_w-1:0]    w_blk_cnt_next;
    logic                  r_ready;
    logic                  r_zero;
    logic                  r_over;
    logic                  r_under;
    logic                  r_perr;
    logic                  w_perr_set;
    logic                  w_done;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [DATA_W-1:0]     w_ram_q;

    assign full      = (r_level == c_depth);
    assign level     = r_level;
    assign ep_ready  = r_ready;
    assign overflow  = r_over;
    assign underflow = r_under;
    assign proto_err = r_perr;
    assign w_wr_acc  = wr_en & ~full;
    assign w_rd_acc  = ep_read & (r_level != '0);
    // The RAM read register has no reset; r_zero masks it after reset or an underflow.
    assign ep_datain = r_zero ? '0 : w_ram_q;

    bt_pipeout_ram #(
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk       (okClk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_ram_q)
    );

    always_comb begin
        w_level_next = r_level;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_level_next = r_level + (DEPTH_LOG2 + 1)'(1);
            2'b01:   w_level_next = r_level - (DEPTH_LOG2 + 1)'(1);
            default: w_level_next = r_level;
        endcase
    end

    always_comb begin
        w_state_next   = r_state;
        w_blk_cnt_next = r_blk_cnt;
        w_perr_set     = 1'b0;
        w_done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (ep_read) w_perr_set = 1'b1;
                if (r_level >= c_block) w_state_next = ARMED;
            end
            ARMED: begin
                if (ep_blockstrobe) begin
                    w_state_next   = XFER;
                    w_blk_cnt_next = c_cnt_w'(ep_read);
                end else if (ep_read) begin
                    w_perr_set = 1'b1;
                end
            end
            XFER: begin
                // A read coincident with a strobe is word 0 of the restarted block.
                if (ep_blockstrobe) begin
                    w_perr_set     = 1'b1;
                    w_blk_cnt_next = c_cnt_w'(ep_read);
                end else if (ep_read) begin
                    w_blk_cnt_next = r_blk_cnt + c_cnt_w'(1);
                    if (r_blk_cnt == c_last) begin
                        w_done       = 1'b1;
                        w_state_next = (w_level_next >= c_block) ? ARMED : IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge okClk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_state   <= IDLE;
            r_blk_cnt <= '0;
            r_ready   <= 1'b0;
            r_zero    <= 1'b1;
            r_over    <= 1'b0;
            r_under   <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            r_level   <= w_level_next;
            r_state   <= w_state_next;
            r_blk_cnt <= w_blk_cnt_next;
            r_ready   <= (w_state_next == ARMED);
            if (ep_read)             r_zero  <= ~w_rd_acc;
            if (wr_en & full)        r_over  <= 1'b1;
            if (ep_read & ~w_rd_acc) r_under <= 1'b1;
            if (w_perr_set)          r_perr  <= 1'b1;
        end
    end

`ifdef BT_PIPEOUT_SOURCE_STATS_EN
    logic [31:0] r_words;
    logic [15:0] r_blocks;

    always_ff @(posedge okClk or negedge rst_n) begin
        if (!rst_n) begin
            r_words  <= '0;
            r_blocks <= '0;
        end else begin
            if (w_rd_acc) r_words  <= r_words + 32'd1;
            if (w_done)   r_blocks <= r_blocks + 16'd1;
        end
    end

    assign words_sent  = r_words;
    assign blocks_sent = r_blocks;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bt_pipeout_source.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bt_pipeout_source                                                       |
// | Directed plus random stimulus against a queue-based model of the pipe.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_bt_pipeout_source;

    localparam int DL2   = 4;
    localparam int BW    = 4;
    localparam int DEPTH = 1 << DL2;

    logic          okClk;
    logic          rst_n;
    logic          wr_en;
    logic [31:0]   wr_data;
    logic          full;
    logic [DL2:0]  level;
    logic          ep_read;
    logic          ep_blockstrobe;
    logic [31:0]   ep_datain;
    logic          ep_ready;
    logic          overflow;
    logic          underflow;
    logic          proto_err;
`ifdef BT_PIPEOUT_SOURCE_STATS_EN
    logic [31:0]   words_sent;
    logic [15:0]   blocks_sent;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO contents as a queue, block progress as a word count.
    logic [31:0] mq[$];
    int          m_mode;   // 0 waiting for a full block, 1 offered, 2 host reading a block
    int          m_cnt;
    logic [31:0] m_data;
    bit          m_over, m_under, m_perr;
    int          m_words, m_blocks;

    bt_pipeout_source #(
        .DEPTH_LOG2  (DL2),
        .BLOCK_WORDS (BW)
    ) dut (
        .okClk          (okClk),
        .rst_n          (rst_n),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .full           (full),
        .level          (level),
        .ep_read        (ep_read),
        .ep_blockstrobe (ep_blockstrobe),
        .ep_datain      (ep_datain),
        .ep_ready       (ep_ready),
        .overflow       (overflow),
        .underflow      (underflow),
        .proto_err      (proto_err)
`ifdef BT_PIPEOUT_SOURCE_STATS_EN
        ,
        .words_sent     (words_sent),
        .blocks_sent    (blocks_sent)
`endif
    );

    initial okClk = 1'b0;
    always #5 okClk = ~okClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("level",     32'(level),     32'(mq.size()));
        chk("full",      32'(full),      32'(mq.size() == DEPTH));
        chk("ep_ready",  32'(ep_ready),  32'(m_mode == 1));
        chk("ep_datain", ep_datain,      m_data);
        chk("overflow",  32'(overflow),  32'(m_over));
        chk("underflow", 32'(underflow), 32'(m_under));
        chk("proto_err", 32'(proto_err), 32'(m_perr));
`ifdef BT_PIPEOUT_SOURCE_STATS_EN
        chk("words_sent",  words_sent,         32'(m_words));
        chk("blocks_sent", 32'(blocks_sent),   32'(m_blocks & 16'hFFFF));
`endif
    endtask

    task automatic model_clear();
        mq.delete();
        m_mode = 0; m_cnt = 0; m_data = '0;
        m_over = 0; m_under = 0; m_perr = 0;
        m_words = 0; m_blocks = 0;
    endtask

    task automatic model_edge(input bit w, input logic [31:0] d, input bit r, input bit s);
        int pre;
        pre = mq.size();
        if (w && pre == DEPTH) m_over = 1;
        if (r) begin
            if (pre > 0) begin
                m_data = mq.pop_front();
                m_words++;
            end else begin
                m_data  = '0;
                m_under = 1;
            end
        end
        if (w && pre != DEPTH) mq.push_back(d);
        case (m_mode)
            0: begin
                if (r) m_perr = 1;
                if (pre >= BW) m_mode = 1;
            end
            1: begin
                if (s) begin
                    m_mode = 2;
                    m_cnt  = r ? 1 : 0;
                end else if (r) begin
                    m_perr = 1;
                end
            end
            default: begin
                if (s) begin
                    m_perr = 1;
                    m_cnt  = r ? 1 : 0;
                end else if (r) begin
                    m_cnt++;
                    if (m_cnt == BW) begin
                        m_cnt = 0;
                        m_blocks++;
                        m_mode = (mq.size() >= BW) ? 1 : 0;
                    end
                end
            end
        endcase
    endtask

    task automatic step(input bit w, input logic [31:0] d, input bit r, input bit s);
        @(negedge okClk);
        wr_en = w; wr_data = d; ep_read = r; ep_blockstrobe = s;
        @(posedge okClk);
        model_edge(w, d, r, s);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 32'h0, 0, 0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        @(negedge okClk);
        wr_en = 0; wr_data = '0; ep_read = 0; ep_blockstrobe = 0;
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check_all();
        @(negedge okClk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 0; wr_data = '0; ep_read = 0; ep_blockstrobe = 0;
        model_clear();
        do_reset();

        // Ready threshold
        for (int i = 0; i < 3; i++) step(1, 32'hA0 + 32'(i), 0, 0);
        idle(2);
        step(1, 32'hA3, 0, 0);
        idle(1);

        // One block, strobe coincident with word 0
        step(0, 32'h0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 32'h0, 1, 0);
        idle(2);

        // Back-to-back blocks
        for (int i = 1; i <= 8; i++) step(1, 32'(i), 0, 0);
        idle(1);
        for (int b = 0; b < 2; b++) begin
            step(0, 32'h0, 0, 1);
            for (int k = 0; k < 4; k++) step(0, 32'h0, 1, 0);
        end
        idle(1);

        // Fill, overflow, then drain with a write on the final read
        for (int i = 0; i < DEPTH; i++) step(1, 32'h100 + 32'(i), 0, 0);
        step(1, 32'hDEAD, 0, 0);
        idle(1);
        for (int b = 0; b < 4; b++) begin
            step(0, 32'h0, 0, 1);
            for (int k = 0; k < 4; k++) step(b == 3 && k == 3, 32'hBEEF, 1, 0);
        end
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 1, 0);
        idle(1);

        // Read while offered but without a strobe
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 32'h200 + 32'(i), 0, 0);
        idle(1);
        step(0, 32'h0, 1, 0);
        idle(1);

        // Strobe in the middle of a block restarts the count
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 32'h300 + 32'(i), 0, 0);
        idle(1);
        step(0, 32'h0, 0, 1);
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 1, 1);
        for (int k = 0; k < 3; k++) step(0, 32'h0, 1, 0);
        idle(2);

        // Reset in the middle of a block
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 32'h400 + 32'(i), 0, 0);
        idle(1);
        step(0, 32'h0, 0, 1);
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 1, 0);
        do_reset();
        idle(1);

        // Random traffic that mostly follows the protocol
        for (int i = 0; i < 400; i++) begin
            bit w, r, s;
            int p;
            w = ($urandom_range(0, 99) < 45);
            p = $urandom_range(0, 99);
            r = 0; s = 0;
            if (m_mode == 1 && p < 50) begin
                s = 1;
                r = (p < 25);
            end else if (m_mode == 2 && p < 70) begin
                r = 1;
                s = (p < 2);
            end else if (p >= 97) begin
                r = 1;
            end
            step(w, $urandom, r, s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
